// File: rtl/mem_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory burst reader:
//   state_t    - burst FSM state encoding (3 bits)
//   RD_LAT_W   - width of the read-latency down-counter
//   PAR_MAX_W  - widest word the parity helper accepts
//   odd_parity - XOR reduction; only used when RD_PARITY_EN is defined
// -----------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      FIN   = 3'd4
   } state_t;

   // Counter holds RD_LAT-1, so two bits cover latencies 1..4.
   localparam int RD_LAT_W  = 2;
   localparam int PAR_MAX_W = 64;

   // Returns 1 when the word has an odd number of ones, i.e. an even-parity
   // word (data plus its parity bit) has been corrupted.
   function automatic logic odd_parity(input logic [PAR_MAX_W-1:0] word);
      odd_parity = ^word;
   endfunction

endpackage

// File: rtl/mem_burst_reader_rd_hold_reg.sv
// -----------------------------------------------------------------------------
// rd_hold_reg
// Enable register that captures a read word and holds it until the next
// capture. Used for out_data (and out_err when parity checking is built in).
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset, clears the register
//   load - capture d on this rising edge
//   d    - word to capture
//   q    - held word
// -----------------------------------------------------------------------------
module rd_hold_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Capture on load, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/mem_burst_reader.sv
// -----------------------------------------------------------------------------
// mem_burst_reader
// Read-side controller for the register memory. Accepts a (base, len) burst
// request, issues one read at a time, waits RD_LAT cycles for the data,
// captures it and offers it on a valid/ready stream. Addresses wrap modulo
// 2**ADDR_W.
// Optional build macro: RD_PARITY_EN - mem_rdata gains an even-parity MSB and
// out_err flags a parity failure alongside out_data.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start          - burst request pulse (only honoured while idle)
//   base_addr, len - first address and word count (0..2**ADDR_W)
//   busy, done     - burst in progress / one-cycle completion pulse
//   mem_addr       - read address, held outside the strobe cycle
//   mem_rd_en      - one-cycle read strobe
//   mem_rdata      - read data, valid RD_LAT cycles after the strobe
//   out_data       - captured word (parity bit stripped)
//   out_err        - parity failure for out_data (RD_PARITY_EN only)
//   out_valid      - out_data valid
//   out_ready      - consumer accepts on out_valid && out_ready
// -----------------------------------------------------------------------------
module mem_burst_reader
   import mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
`ifdef RD_PARITY_EN
   input  logic [DATA_W:0]   mem_rdata,
   output logic              out_err,
`else
   input  logic [DATA_W-1:0] mem_rdata,
`endif
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

`ifdef RD_PARITY_EN
   localparam int HOLD_W = DATA_W + 1;
`else
   localparam int HOLD_W = DATA_W;
`endif

   state_t                state_r;
   logic [ADDR_W-1:0]     addr_r;
   logic [ADDR_W:0]       remaining_r;
   logic [RD_LAT_W-1:0]   lat_r;
   logic [ADDR_W-1:0]     addr_next_s;
   logic                  capture_s;
   logic [HOLD_W-1:0]     hold_d_s;
   logic [HOLD_W-1:0]     hold_q_s;

   assign addr_next_s = addr_r + ADDR_W'(1);
   // Data is valid in the last WAIT cycle, when the countdown has reached zero.
   assign capture_s   = (state_r == WAIT) && (lat_r == '0);

`ifdef RD_PARITY_EN
   assign hold_d_s = {odd_parity(PAR_MAX_W'(mem_rdata)), mem_rdata[DATA_W-1:0]};
   assign out_err  = hold_q_s[DATA_W];
`else
   assign hold_d_s = mem_rdata;
`endif
   assign out_data = hold_q_s[DATA_W-1:0];

   rd_hold_reg #(
      .W    (HOLD_W)
   ) u_hold (
      .clk  (clk),
      .rst  (rst),
      .load (capture_s),
      .d    (hold_d_s),
      .q    (hold_q_s)
   );

   // Burst FSM with its counters and registered control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         addr_r      <= '0;
         remaining_r <= '0;
         lat_r       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_addr    <= '0;
         mem_rd_en   <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done      <= 1'b0;
               mem_rd_en <= 1'b0;
               if (start) begin
                  if (len != '0) begin
                     addr_r      <= base_addr;
                     remaining_r <= len;
                     busy        <= 1'b1;
                     // Strobe is registered so it is high exactly in ISSUE.
                     mem_addr    <= base_addr;
                     mem_rd_en   <= 1'b1;
                     state_r     <= ISSUE;
                  end else begin
                     done    <= 1'b1;
                     state_r <= FIN;
                  end
               end
            end
            ISSUE: begin
               mem_rd_en <= 1'b0;
               lat_r     <= RD_LAT_W'(RD_LAT - 1);
               state_r   <= WAIT;
            end
            WAIT: begin
               if (lat_r == '0) begin
                  out_valid <= 1'b1;
                  state_r   <= HOLD;
               end else begin
                  lat_r <= lat_r - RD_LAT_W'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  remaining_r <= remaining_r - (ADDR_W+1)'(1);
                  addr_r      <= addr_next_s;
                  if (remaining_r > (ADDR_W+1)'(1)) begin
                     mem_addr  <= addr_next_s;
                     mem_rd_en <= 1'b1;
                     state_r   <= ISSUE;
                  end else begin
                     done    <= 1'b1;
                     state_r <= FIN;
                  end
               end
            end
            FIN: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               done      <= 1'b0;
               mem_rd_en <= 1'b0;
               out_valid <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_reader
// Scoreboard bench: each burst request pushes its expected reads (address,
// cycle) and words (data, parity flag, cycle) into queues; a negedge monitor
// pops and compares on every read strobe and every handshake. A behavioural
// memory returns mem[addr] exactly RD_LAT cycles after a strobe and random
// garbage at all other times. Build with +define+RD_PARITY_EN for parity.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_burst_reader;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int RD_LAT = 3;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int PER    = RD_LAT + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   len = '0;
   logic              out_ready = 1'b0;
   logic              busy, done, mem_rd_en, out_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] out_data;
`ifdef RD_PARITY_EN
   logic [DATA_W:0]   mem_rdata;
   logic              out_err;
`else
   logic [DATA_W-1:0] mem_rdata;
`endif

   mem_burst_reader #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .RD_LAT    (RD_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
`ifdef RD_PARITY_EN
      .out_err   (out_err),
`endif
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- behavioural memory ----------------
   logic [DATA_W-1:0] mem  [DEPTH];
   logic              flip [DEPTH];
   logic              pv   [RD_LAT];
   logic [ADDR_W-1:0] pa   [RD_LAT];
   logic [DATA_W-1:0] garbage = '0;
   logic              gpar = 1'b0;

   initial begin
      for (int i = 0; i < RD_LAT; i++) begin
         pv[i] = 1'b0;
         pa[i] = '0;
      end
   end

   always @(posedge clk) begin
      garbage <= DATA_W'($urandom);
      gpar    <= 1'($urandom);
      for (int i = RD_LAT - 1; i > 0; i--) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
      end
      pv[0] <= mem_rd_en;
      pa[0] <= mem_addr;
   end

   logic [DATA_W-1:0] rdata_word;
   assign rdata_word = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : garbage;
`ifdef RD_PARITY_EN
   assign mem_rdata = {pv[RD_LAT-1] ? ((^rdata_word) ^ flip[pa[RD_LAT-1]]) : gpar, rdata_word};
`else
   assign mem_rdata = rdata_word;
`endif

   // ---------------- scoreboard ----------------
   typedef struct { logic [DATA_W-1:0] data; logic err; int cyc; } word_t;
   typedef struct { logic [ADDR_W-1:0] addr; int cyc; } rd_t;
   word_t word_q[$];
   rd_t   rd_q[$];

   // Expected reads and words of a burst; cycles only when out_ready stays high.
   function automatic void push_burst(input int b, input int n, input int sc, input bit timed);
      for (int k = 0; k < n; k++) begin
         int a;
         a = (b + k) % DEPTH;
         rd_q.push_back('{addr: ADDR_W'(a), cyc: timed ? sc + 1 + k * PER : -1});
         word_q.push_back('{data: mem[a], err: flip[a], cyc: timed ? sc + 2 + RD_LAT + k * PER : -1});
      end
   endfunction

   // ---------------- monitor ----------------
   int                hs_cnt = 0;
   int                rd_cnt = 0;
   logic              held = 1'b0;
   logic [DATA_W-1:0] held_data = '0;
   word_t             w;
   rd_t               r;

   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (mem_rd_en) begin
            rd_cnt++;
            if (rd_q.size() == 0) begin
               chk("unexpected_rd_en", 32'(1), 32'(0));
            end else begin
               r = rd_q.pop_front();
               chk("rd_addr", 32'(mem_addr), 32'(r.addr));
               if (r.cyc >= 0) chk("rd_cycle", 32'(cyc), 32'(r.cyc));
            end
         end
         if (held) begin
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_data", 32'(out_data), 32'(held_data));
            chk("hold_no_rd", 32'(mem_rd_en), 32'(0));
         end
         held      = out_valid && !out_ready;
         held_data = out_data;
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (word_q.size() == 0) begin
               chk("unexpected_word", 32'(1), 32'(0));
            end else begin
               w = word_q.pop_front();
               chk("out_data", 32'(out_data), 32'(w.data));
`ifdef RD_PARITY_EN
               chk("out_err", 32'(out_err), 32'(w.err));
`endif
               if (w.cyc >= 0) chk("word_cycle", 32'(cyc), 32'(w.cyc));
            end
         end
      end
   end

   // ---------------- driver ----------------
   // mode 0: ready high; 1: random ready; 2: 5-cycle stall on word 2;
   // 3: ready high plus a start pulse injected mid-burst.
   task automatic run_burst(input int b, input int n, input int mode);
      int sc, t, hs0, stall, dcyc;
      bit got;
      @(posedge clk); #1;
      base_addr = ADDR_W'(b);
      len       = (ADDR_W+1)'(n);
      start     = 1'b1;
      out_ready = 1'b1;
      sc        = cyc;
      push_burst(b, n, sc, (mode == 0) || (mode == 3));
      hs0 = hs_cnt; stall = 0; got = 1'b0; t = 0; dcyc = 0;
      @(posedge clk); #1;
      start = 1'b0;
      if (n > 0) chk("busy_after_start", 32'(busy), 32'(1));
      while (!got && t < 600) begin
         if (done) begin
            got  = 1'b1;
            dcyc = cyc;
         end else begin
            case (mode)
               1: out_ready = 1'($urandom_range(0, 1));
               2: begin
                  if (out_valid && (hs_cnt - hs0 == 1) && stall < 5) begin
                     out_ready = 1'b0;
                     stall++;
                  end else begin
                     out_ready = 1'b1;
                  end
               end
               default: out_ready = 1'b1;
            endcase
            if (mode == 3 && t == 2) begin
               start     = 1'b1;
               base_addr = ADDR_W'(b + 7);
               len       = (ADDR_W+1)'(2);
            end else begin
               start = 1'b0;
            end
            @(posedge clk); #1;
            t++;
         end
      end
      start = 1'b0;
      chk("done_seen", 32'(got), 32'(1));
      if (got) begin
         if (mode == 0 || mode == 3)
            chk("done_cycle", 32'(dcyc), 32'((n == 0) ? sc + 1 : sc + 3 + RD_LAT + (n - 1) * PER));
         @(posedge clk); #1;
         chk("done_one_cycle", 32'(done), 32'(0));
         chk("busy_after_done", 32'(busy), 32'(0));
      end
      chk("words_left", 32'(word_q.size()), 32'(0));
      chk("reads_left", 32'(rd_q.size()), 32'(0));
      if (mode == 2) chk("stall_cycles", 32'(stall), 32'(5));
      word_q.delete();
      rd_q.delete();
      out_ready = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"},      32'(busy),      32'(0));
      chk({tag, "_done"},      32'(done),      32'(0));
      chk({tag, "_rd_en"},     32'(mem_rd_en), 32'(0));
      chk({tag, "_mem_addr"},  32'(mem_addr),  32'(0));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
      chk({tag, "_out_data"},  32'(out_data),  32'(0));
`ifdef RD_PARITY_EN
      chk({tag, "_out_err"},   32'(out_err),   32'(0));
`endif
   endtask

   initial begin
      int t, r0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]  = DATA_W'(i * 3);
         flip[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      run_burst(2, 3, 0);           // data 6, 9, 12
      run_burst(14, 4, 0);          // wraps 14, 15, 0, 1
      run_burst(5, 4, 2);           // backpressure on word 2
      run_burst(6, 0, 0);           // len=0: done, no reads
      run_burst(1, 3, 3);           // start while busy is ignored

      // Reset during WAIT of the second word.
      @(posedge clk); #1;
      base_addr = ADDR_W'(5);
      len       = (ADDR_W+1)'(4);
      start     = 1'b1;
      out_ready = 1'b1;
      push_burst(5, 4, cyc, 1'b1);
      r0 = rd_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0;
      while (rd_cnt < r0 + 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("second_read_seen", 32'(rd_cnt >= r0 + 2), 32'(1));
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_idle_outputs("async_reset");
      word_q.delete();
      rd_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_done_after_reset", 32'(done), 32'(0));
         chk("idle_after_reset", 32'(busy), 32'(0));
      end
      run_burst(9, 3, 0);

`ifdef RD_PARITY_EN
      mem[3]  = 8'hA5;
      flip[3] = 1'b0;
      mem[4]  = 8'hA5;
      flip[4] = 1'b1;
      run_burst(3, 2, 0);
      flip[4] = 1'b0;
`endif

      // Full-array burst, then randomized bursts.
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      run_burst(9, DEPTH, 0);
      for (int k = 0; k < 24; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DATA_W'($urandom);
`ifdef RD_PARITY_EN
            flip[i] = 1'($urandom_range(0, 1));
`endif
         end
         run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                   int'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
